// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: adds two WIDTH-bit operands plus carry-in LSB-first,
// one full-adder step per clock through a single carry flip-flop, then reports
// sum, carry-out and signed overflow alongside a one-cycle done pulse.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             s_bit,
  output logic             s_valid,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  // Holds the WIDTH-1 sum bits produced so far; the last bit is merged in
  // combinationally on the completion edge, so no extra register stage is needed.
  logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic             s_raw;
  logic             carry_nxt;
  logic [WIDTH-1:0] sum_full;

  // Next-state, datapath update and output decode for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_sr_d  = sum_sr_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    busy      = 1'b0;
    s_valid   = 1'b0;
    done      = 1'b0;
    s_bit     = 1'b0;

    s_raw     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_nxt = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    sum_full  = {s_raw, sum_sr_q};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        s_valid  = 1'b1;
        s_bit    = s_raw;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_full[WIDTH-1:1];
        carry_d  = carry_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = sum_full;
          cout_d  = carry_nxt;
          ovf_d   = carry_q ^ carry_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset clears everything, aborting any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and randomised bench for bit_serial_adder at WIDTH=8.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, s_bit, s_valid, done, cout, ovf;
  logic [7:0] sum;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .s_bit(s_bit), .s_valid(s_valid), .done(done),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE, checking serial bits, latency and the done pulse.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic [7:0] es, input logic ec, input logic eo);
    a = av; b = bv; cin = ci; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~ci;
    for (int i = 0; i < 8; i++) begin
      check("run_valid", {31'd0, s_valid}, 32'd1);
      check("run_busy",  {31'd0, busy},    32'd1);
      check("run_done",  {31'd0, done},    32'd0);
      check("s_bit",     {31'd0, s_bit},   {31'd0, es[i]});
      tick();
    end
    check("done_hi",   {31'd0, done},    32'd1);
    check("done_busy", {31'd0, busy},    32'd1);
    check("done_sv",   {31'd0, s_valid}, 32'd0);
    check("sum",       {24'd0, sum},     {24'd0, es});
    check("cout",      {31'd0, cout},    {31'd0, ec});
    check("ovf",       {31'd0, ovf},     {31'd0, eo});
    tick();
    check("done_lo",   {31'd0, done},    32'd0);
    check("idle_busy", {31'd0, busy},    32'd0);
    check("sum_hold",  {24'd0, sum},     {24'd0, es});
  endtask

  initial begin
    logic [7:0] ra, rb, es;
    logic       rc, ec, eo;
    logic [8:0] full;
    logic [7:0] va [4];
    logic [7:0] vb [4];

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    check("rst_busy",  {31'd0, busy},    32'd0);
    check("rst_done",  {31'd0, done},    32'd0);
    check("rst_sv",    {31'd0, s_valid}, 32'd0);
    check("rst_sbit",  {31'd0, s_bit},   32'd0);
    check("rst_sum",   {24'd0, sum},     32'd0);
    check("rst_cout",  {31'd0, cout},    32'd0);
    check("rst_ovf",   {31'd0, ovf},     32'd0);
    rst = 1'b0;
    tick();
    check("idle_nostart", {31'd0, busy}, 32'd0);

    do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Continuous start: operands presented only at the IDLE cycle are used.
    va[0] = 8'h12; vb[0] = 8'h34;
    va[1] = 8'hF0; vb[1] = 8'h0F;
    va[2] = 8'h64; vb[2] = 8'h64;
    va[3] = 8'h9C; vb[3] = 8'hA5;
    start = 1'b1; cin = 1'b0;
    for (int op = 0; op < 4; op++) begin
      check("cont_idle", {31'd0, busy}, 32'd0);
      a = va[op]; b = vb[op];
      tick();
      for (int i = 0; i < 8; i++) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        check("cont_run", {31'd0, s_valid}, 32'd1);
        tick();
      end
      full = {1'b0, va[op]} + {1'b0, vb[op]};
      check("cont_done", {31'd0, done}, 32'd1);
      check("cont_sum",  {24'd0, sum},  {24'd0, full[7:0]});
      check("cont_cout", {31'd0, cout}, {31'd0, full[8]});
      cin = 1'b0;
      tick();
      check("cont_gap_done", {31'd0, done}, 32'd0);
    end
    check("cont_gap_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    tick();
    check("cont_stop", {31'd0, busy}, 32'd0);

    // Reset mid-run; prior result 0x80/ovf=1 must be cleared.
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    a = 8'h55; b = 8'h55; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_sv", {31'd0, s_valid}, 32'd1);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("abort_busy", {31'd0, busy},    32'd0);
    check("abort_sv",   {31'd0, s_valid}, 32'd0);
    check("abort_sbit", {31'd0, s_bit},   32'd0);
    check("abort_done", {31'd0, done},    32'd0);
    check("abort_sum",  {24'd0, sum},     32'd0);
    check("abort_cout", {31'd0, cout},    32'd0);
    check("abort_ovf",  {31'd0, ovf},     32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_nodone", {31'd0, done}, 32'd0);
    end
    do_op(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);

    // Randomised operations against an arithmetic reference.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      es = full[7:0];
      ec = full[8];
      eo = (ra[7] == rb[7]) && (es[7] != ra[7]);
      do_op(ra, rb, rc, es, ec, eo);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
